// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch program-counter stage. Advances the PC by 4 on each unstalled
//   cycle. A taken branch or jump resolved in EXE redirects the PC to its
//   word-aligned target and flushes the younger IF/ID instructions. An HLT
//   in EXE freezes the core until reset. Taken redirects are counted in a
//   saturating counter.
//
// Ports
//   i_Clk, i_Rst_n        clock (rising edge), asynchronous active-low reset
//   i_BranchBitExe        EXE holds a conditional branch
//   i_BranchVerification  branch condition true (used only with i_BranchBitExe)
//   i_BranchTargetExe     branch target
//   i_JumpExe             EXE holds an unconditional register jump
//   i_JumpTargetExe       jump target
//   i_HaltExe             EXE holds HLT
//   i_Stall               hazard stall; holds the PC
//   o_PC                  registered fetch address
//   o_PCPlus4             o_PC + 4, wraps modulo 2^32
//   o_Flush               squash IF/ID and ID/EXE at the coming edge
//   o_FetchValid          the fetch at o_PC is valid this cycle
//   o_Halted              core halted (registered)
//   o_Misaligned          one-cycle pulse: last redirect target was not word aligned
//   o_TakenCount          saturating count of taken redirects
module pc_redirect_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   input  logic             i_BranchBitExe,
   input  logic             i_BranchVerification,
   input  logic [31:0]      i_BranchTargetExe,
   input  logic             i_JumpExe,
   input  logic [31:0]      i_JumpTargetExe,
   input  logic             i_HaltExe,
   input  logic             i_Stall,
   output logic [31:0]      o_PC,
   output logic [31:0]      o_PCPlus4,
   output logic             o_Flush,
   output logic             o_FetchValid,
   output logic             o_Halted,
   output logic             o_Misaligned,
   output logic [CNT_W-1:0] o_TakenCount
);

   typedef enum logic {
      RUN,
      HALTED
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic               misaligned_q, misaligned_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               running;
   logic               redirect;
   logic [31:0]        target;
   logic [31:0]        pc_plus4;

   // Redirect decode. Halt in EXE suppresses any simultaneous redirect.
   always_comb begin
      running  = (state_q == RUN);
      redirect = running & ~i_HaltExe &
                 ((i_BranchBitExe & i_BranchVerification) | i_JumpExe);
      target   = i_JumpExe ? i_JumpTargetExe : i_BranchTargetExe;
      pc_plus4 = pc_q + 32'd4;
   end

   // State register
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q      <= RUN;
         pc_q         <= RESET_VECTOR;
         misaligned_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         misaligned_q <= misaligned_d;
         count_q      <= count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      misaligned_d = 1'b0;
      count_d      = count_q;
      unique case (state_q)
         RUN: begin
            if (i_HaltExe) begin
               state_d = HALTED;
            end else if (redirect) begin
               pc_d         = {target[31:2], 2'b00};
               misaligned_d = |target[1:0];
               if (count_q != '1) count_d = count_q + 1'b1;
            end else if (!i_Stall) begin
               pc_d = pc_plus4;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: state_d = RUN;
      endcase
   end

   // Output logic
   always_comb begin
      o_PC         = pc_q;
      o_PCPlus4    = pc_plus4;
      o_Flush      = redirect;
      o_FetchValid = running & ~i_Stall & ~redirect;
      o_Halted     = (state_q == HALTED);
      o_Misaligned = misaligned_q;
      o_TakenCount = count_q;
   end

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst_n;
   logic          br_bit, br_ver, jmp, hlt, stall;
   logic [31:0]   br_tgt, jmp_tgt;
   logic [31:0]   pc, pc4;
   logic          flush, fvalid, halted, misal;
   logic [CW-1:0] tcount;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   pc_redirect_unit #(
      .RESET_VECTOR (32'h0000_0000),
      .CNT_W        (CW)
   ) dut (
      .i_Clk                (clk),
      .i_Rst_n              (rst_n),
      .i_BranchBitExe       (br_bit),
      .i_BranchVerification (br_ver),
      .i_BranchTargetExe    (br_tgt),
      .i_JumpExe            (jmp),
      .i_JumpTargetExe      (jmp_tgt),
      .i_HaltExe            (hlt),
      .i_Stall              (stall),
      .o_PC                 (pc),
      .o_PCPlus4            (pc4),
      .o_Flush              (flush),
      .o_FetchValid         (fvalid),
      .o_Halted             (halted),
      .o_Misaligned         (misal),
      .o_TakenCount         (tcount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      br_bit = 0; br_ver = 0; jmp = 0; hlt = 0; stall = 0;
      br_tgt = 32'h0; jmp_tgt = 32'h0;
   endtask

   task automatic taken_branch(input logic [31:0] t);
      idle();
      br_bit = 1; br_ver = 1; br_tgt = t;
   endtask

   initial begin
      idle();
      rst_n = 0;
      #1;
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_halted", {31'b0, halted}, 32'h0);
      check_eq("rst_mis", {31'b0, misal}, 32'h0);
      check_eq("rst_cnt", {28'b0, tcount}, 32'h0);
      check_eq("rst_flush", {31'b0, flush}, 32'h0);
      @(negedge clk);
      rst_n = 1;
      #1;
      check_eq("run_pc0", pc, 32'h0);
      check_eq("run_fv", {31'b0, fvalid}, 32'h1);
      step(); check_eq("run_pc4", pc, 32'h4);
      step(); check_eq("run_pc8", pc, 32'h8);
      step(); check_eq("run_pc12", pc, 32'hC);
      check_eq("run_flush", {31'b0, flush}, 32'h0);
      check_eq("run_cnt", {28'b0, tcount}, 32'h0);
      for (int i = 0; i < 5; i++) step();
      check_eq("pc_20", pc, 32'h20);

      // taken branch
      taken_branch(32'h100);
      #1;
      check_eq("br_flush", {31'b0, flush}, 32'h1);
      check_eq("br_fv", {31'b0, fvalid}, 32'h0);
      step(); idle(); #1;
      check_eq("br_pc", pc, 32'h100);
      check_eq("br_cnt", {28'b0, tcount}, 32'h1);

      // not-taken branch
      br_bit = 1; br_ver = 0; br_tgt = 32'h300; #1;
      check_eq("nt_flush", {31'b0, flush}, 32'h0);
      check_eq("nt_fv", {31'b0, fvalid}, 32'h1);
      step(); idle(); #1;
      check_eq("nt_pc", pc, 32'h104);
      check_eq("nt_cnt", {28'b0, tcount}, 32'h1);

      // stall + misaligned jump
      stall = 1; jmp = 1; jmp_tgt = 32'h203; #1;
      check_eq("sj_flush", {31'b0, flush}, 32'h1);
      check_eq("sj_fv", {31'b0, fvalid}, 32'h0);
      step(); idle(); #1;
      check_eq("sj_pc", pc, 32'h200);
      check_eq("sj_mis", {31'b0, misal}, 32'h1);
      check_eq("sj_cnt", {28'b0, tcount}, 32'h2);
      step();
      check_eq("sj_mis_clr", {31'b0, misal}, 32'h0);
      check_eq("sj_pc_next", pc, 32'h204);

      // plain stall
      stall = 1; #1;
      check_eq("st_fv", {31'b0, fvalid}, 32'h0);
      step(); idle(); #1;
      check_eq("st_pc", pc, 32'h204);

      // jump wins over taken branch
      taken_branch(32'h500); jmp = 1; jmp_tgt = 32'h400;
      step(); idle(); #1;
      check_eq("jb_pc", pc, 32'h400);
      check_eq("jb_cnt", {28'b0, tcount}, 32'h3);
      check_eq("jb_mis", {31'b0, misal}, 32'h0);

      // back-to-back redirects
      taken_branch(32'h600);
      step();
      check_eq("bb_pc1", pc, 32'h600);
      taken_branch(32'h700); #1;
      check_eq("bb_flush2", {31'b0, flush}, 32'h1);
      step(); idle(); #1;
      check_eq("bb_pc2", pc, 32'h700);
      check_eq("bb_cnt", {28'b0, tcount}, 32'h5);

      // wrap at top of address space
      jmp = 1; jmp_tgt = 32'hFFFF_FFFC;
      step(); idle(); #1;
      check_eq("wr_pc", pc, 32'hFFFF_FFFC);
      check_eq("wr_pc4", pc4, 32'h0);
      step();
      check_eq("wr_next", pc, 32'h0);

      // async reset mid-cycle, then counter saturation
      rst_n = 0; #1;
      check_eq("rst2_cnt", {28'b0, tcount}, 32'h0);
      check_eq("rst2_pc", pc, 32'h0);
      #1 rst_n = 1;
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         taken_branch(32'h40); #1;
         check_eq($sformatf("sat_flush%0d", i), {31'b0, flush}, 32'h1);
         step();
      end
      idle(); #1;
      check_eq("sat_cnt", {28'b0, tcount}, 32'hF);
      check_eq("sat_pc", pc, 32'h40);

      // halt beats simultaneous branch
      taken_branch(32'h80); hlt = 1; #1;
      check_eq("h_flush", {31'b0, flush}, 32'h0);
      step(); idle(); #1;
      check_eq("h_pc", pc, 32'h40);
      check_eq("h_halted", {31'b0, halted}, 32'h1);
      check_eq("h_fv", {31'b0, fvalid}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         br_bit = 1; br_ver = 1; br_tgt = 32'h1000 + i;
         jmp = i[0]; jmp_tgt = 32'h2000; stall = i[1]; hlt = 0;
         #1;
         check_eq("hd_flush", {31'b0, flush}, 32'h0);
         check_eq("hd_fv", {31'b0, fvalid}, 32'h0);
         step();
         check_eq("hd_pc", pc, 32'h40);
         check_eq("hd_halted", {31'b0, halted}, 32'h1);
         check_eq("hd_cnt", {28'b0, tcount}, 32'hF);
      end
      idle();
      rst_n = 0; #1;
      check_eq("hr_pc", pc, 32'h0);
      check_eq("hr_halted", {31'b0, halted}, 32'h0);
      check_eq("hr_cnt", {28'b0, tcount}, 32'h0);
      #1 rst_n = 1;
      step();
      check_eq("hr_run", pc, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter stage that directly consumes the branch-condition verdict from the EXE stage.
- Holds the fetch PC and advances it by 4 each unstalled cycle.
- On a taken branch or jump in EXE, redirects the PC to the target and flushes the IF/ID younger instructions.
- Also handles HLT (halt) and counts taken redirects for performance monitoring.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_BranchBitExe  input  1  instruction in EXE is a conditional branch.
- i_BranchVerification  input  1  branch condition true (from condition checker); ignored unless i_BranchBitExe=1.
- i_BranchTargetExe  input  32  branch target computed in EXE.
- i_JumpExe  input  1  instruction in EXE is an unconditional register jump.
- i_JumpTargetExe  input  32  jump target.
- i_HaltExe  input  1  HLT instruction in EXE.
- i_Stall  input  1  hazard stall from ID; freezes PC.
- o_PC  output  32  current fetch address (register).
- o_PCPlus4  output  32  o_PC + 4, combinational, wraps modulo 2^32.
- o_Flush  output  1  combinational; squash IF/ID and ID/EXE contents at the coming edge.
- o_FetchValid  output  1  combinational; fetch at o_PC is valid this cycle.
- o_Halted  output  1  registered; core halted.
- o_Misaligned  output  1  registered one-cycle pulse; the last redirect target had bits[1:0] != 0.
- o_TakenCount  output  CNT_W  saturating count of redirects.

Behaviour:
- Reset (asynchronous, active-low), applied at any time including mid-flush or while halted:
  - o_PC=RESET_VECTOR, state=RUN, o_Halted=0, o_Misaligned=0, o_TakenCount=0.
  - Combinational outputs follow from these register values.
- States: RUN, HALTED.
- redirect = state==RUN & ~i_HaltExe & ((i_BranchBitExe & i_BranchVerification) | i_JumpExe).
- target = i_JumpExe ? i_JumpTargetExe : i_BranchTargetExe. A jump wins if both strobes are set.
- Next-PC priority in RUN, evaluated at each rising edge:
  1. i_HaltExe: PC held; state goes to HALTED; o_Halted=1 from the next cycle. Halt beats a simultaneous redirect.
  2. redirect: o_PC <= {target[31:2],2'b00}. Redirect overrides i_Stall.
  3. i_Stall: PC held.
  4. Otherwise: o_PC <= o_PC+4. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- o_Flush = redirect. It is asserted in the same cycle the verdict is present, for exactly one cycle per redirect.
  - Back-to-back redirects in consecutive cycles each flush and each reload the PC.
- o_FetchValid = state==RUN & ~i_Stall & ~redirect.
- o_Misaligned <= redirect & (target[1:0]!=0). Otherwise it is 0 on the next edge.
- o_TakenCount increments by 1 on each redirect edge and holds at all-ones (no wrap).
- Not-taken branches (i_BranchBitExe=1, i_BranchVerification=0) advance normally and do not count.
- HALTED:
  - All inputs are ignored; o_PC frozen; o_Flush=0; o_FetchValid=0; o_TakenCount frozen.
  - Exit is by reset only.
- No X propagation: unused targets do not affect state.

Test Plan:
- Reset release with RESET_VECTOR=0, no stall, 4 cycles -> o_PC reads 0,4,8,12; o_Flush=0; o_TakenCount=0.
- o_PC=0x20, i_BranchBitExe=1, i_BranchVerification=1, target=0x100 -> o_Flush=1 that cycle; next o_PC=0x100; o_TakenCount=1. Repeat with verification=0 -> o_PC=0x24, count unchanged.
- i_Stall=1 with a simultaneous taken jump to 0x203 -> o_PC=0x200 next cycle; o_Misaligned pulses for one cycle; o_FetchValid=0 during the redirect cycle.
- o_PC=0x40, i_HaltExe=1 with a simultaneous taken branch to 0x80 -> o_PC stays 0x40; o_Halted=1. Further branches, jumps and stalls leave all outputs unchanged. Assert i_Rst_n=0 mid-halt -> immediate return to RESET_VECTOR with o_Halted=0.
- Taken branches on every cycle for 2^CNT_W+3 cycles (CNT_W=4 build) -> o_TakenCount saturates at 15; o_Flush is high every cycle.
- o_PC=0xFFFF_FFFC, no stall -> o_PCPlus4=0 and next o_PC=0x0000_0000.
